xosera_bus_if: RTL and testbench

Host-bus front end between the board-level m68k pins and the Xosera register file. It synchronizes the asynchronous 8-bit bus (select, read/not-write, byte select, 4-bit register number, data) into the pixel-clock domain, deglitches select and issues exactly one single-cycle read or write strobe per bus cycle. It also returns the selected byte of register read data to the pin-level tri-state driver.

---
 rtl/xosera_bus_if.sv | 124 ++++++++++++
 tb/tb_xosera_bus_if.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/xosera_bus_if.sv
// m68k host-bus front end: synchronizes pins, deglitches select, one rd/wr strobe per bus cycle.
// Strobe SYNC_STAGES+DEGLITCH clocks after cs_n falls; read byte lands 2 clocks after rd strobe; no backpressure.
module xosera_bus_if #(
  parameter int SYNC_STAGES = 2,
  parameter int DEGLITCH    = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        bus_cs_n_i,
  input  logic        bus_rd_nwr_i,
  input  logic        bus_bytesel_i,
  input  logic [3:0]  bus_reg_num_i,
  input  logic [7:0]  bus_data_i,
  output logic [7:0]  bus_data_o,
  input  logic [15:0] reg_rd_data_i,
  output logic        wr_strobe_o,
  output logic        rd_strobe_o,
  output logic [3:0]  reg_num_o,
  output logic        bytesel_o,
  output logic [7:0]  wr_data_o
);

  localparam int         BUS_W = 15;
  localparam logic [3:0] DEG4  = 4'(DEGLITCH);

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, ARM, ACTIVE} state_t;

  logic [BUS_W-1:0] sync_q [SYNC_STAGES];

  // Synchronizer chain deliberately has no reset.
  always_ff @(posedge clk) begin
    sync_q[0] <= {bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  logic       s_cs_n;
  logic       s_rd_nwr;
  logic       s_bytesel;
  logic [3:0] s_reg_num;
  logic [7:0] s_data;

  assign s_cs_n    = sync_q[SYNC_STAGES-1][14];
  assign s_rd_nwr  = sync_q[SYNC_STAGES-1][13];
  assign s_bytesel = sync_q[SYNC_STAGES-1][12];
  assign s_reg_num = sync_q[SYNC_STAGES-1][11:8];
  assign s_data    = sync_q[SYNC_STAGES-1][7:0];

  state_t     state, state_nxt;
  logic [3:0] count, count_nxt;
  logic       fire;
  logic       rd_pending;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    fire      = 1'b0;
    case (state)
      WAIT_HIGH: begin
        if (s_cs_n) state_nxt = IDLE;
      end
      IDLE: begin
        if (!s_cs_n) begin
          if (DEGLITCH == 1) begin
            fire      = 1'b1;
            state_nxt = ACTIVE;
          end else begin
            count_nxt = 4'd1;
            state_nxt = ARM;
          end
        end
      end
      ARM: begin
        if (s_cs_n) begin
          count_nxt = 4'd0;
          state_nxt = IDLE;
        end else if (count == DEG4) begin
          fire      = 1'b1;
          state_nxt = ACTIVE;
        end else begin
          count_nxt = count + 4'd1;
        end
      end
      ACTIVE: begin
        if (s_cs_n) begin
          count_nxt = 4'd0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state       <= WAIT_HIGH;
      count       <= 4'd0;
      wr_strobe_o <= 1'b0;
      rd_strobe_o <= 1'b0;
      reg_num_o   <= 4'd0;
      bytesel_o   <= 1'b0;
      wr_data_o   <= 8'd0;
      rd_pending  <= 1'b0;
      bus_data_o  <= 8'd0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      wr_strobe_o <= fire & ~s_rd_nwr;
      rd_strobe_o <= fire & s_rd_nwr;
      if (fire) begin
        reg_num_o <= s_reg_num;
        bytesel_o <= s_bytesel;
        wr_data_o <= s_data;
      end
      // Register file presents read data the cycle after the strobe.
      rd_pending <= rd_strobe_o;
      if (rd_pending) begin
        bus_data_o <= bytesel_o ? reg_rd_data_i[7:0] : reg_rd_data_i[15:8];
      end
    end
  end

endmodule

// File: tb/tb_xosera_bus_if.sv
// Bench for xosera_bus_if: pin-level timeline replayed against an edge-indexed reference model.
module tb_xosera_bus_if;

  localparam int SYNC = 2;
  localparam int DEG  = 2;
  localparam int OFS  = (DEG == 1) ? 0 : DEG;
  localparam int N    = 3000;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        bus_cs_n_i;
  logic        bus_rd_nwr_i;
  logic        bus_bytesel_i;
  logic [3:0]  bus_reg_num_i;
  logic [7:0]  bus_data_i;
  logic [7:0]  bus_data_o;
  logic [15:0] reg_rd_data_i;
  logic        wr_strobe_o;
  logic        rd_strobe_o;
  logic [3:0]  reg_num_o;
  logic        bytesel_o;
  logic [7:0]  wr_data_o;

  always #5 clk = ~clk;

  xosera_bus_if #(.SYNC_STAGES(SYNC), .DEGLITCH(DEG)) dut (
    .clk(clk), .reset_i(reset_i),
    .bus_cs_n_i(bus_cs_n_i), .bus_rd_nwr_i(bus_rd_nwr_i), .bus_bytesel_i(bus_bytesel_i),
    .bus_reg_num_i(bus_reg_num_i), .bus_data_i(bus_data_i), .bus_data_o(bus_data_o),
    .reg_rd_data_i(reg_rd_data_i), .wr_strobe_o(wr_strobe_o), .rd_strobe_o(rd_strobe_o),
    .reg_num_o(reg_num_o), .bytesel_o(bytesel_o), .wr_data_o(wr_data_o)
  );

  // Pin values presented before edge i.
  bit        p_cs [N];
  bit        p_rd [N];
  bit        p_bs [N];
  bit        p_rst[N];
  bit [3:0]  p_reg[N];
  bit [7:0]  p_dat[N];
  bit [15:0] p_rdd[N];
  int        len = 0;

  // Expected outputs just after edge e.
  bit        e_wr [N];
  bit        e_rd [N];
  bit        e_bs [N];
  bit [3:0]  e_reg[N];
  bit [7:0]  e_wd [N];
  bit [7:0]  e_bd [N];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input int e, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, e, got, exp);
    end
  endtask

  task automatic seg(input int n, input bit cs, input bit rd, input bit bs, input bit [3:0] rg,
                     input bit [7:0] d, input bit [15:0] rdd, input bit rst);
    for (int k = 0; k < n; k++) begin
      if (len < N) begin
        p_cs[len] = cs; p_rd[len] = rd; p_bs[len] = bs; p_reg[len] = rg;
        p_dat[len] = d; p_rdd[len] = rdd; p_rst[len] = rst;
        len++;
      end
    end
  endtask

  function automatic bit scs(input int e);
    return (e >= SYNC) ? p_cs[e-SYNC] : 1'b1;
  endfunction

  // A low run in the synchronized domain that starts at edge a (high at a-1) strobes at a+OFS,
  // provided it is still low there and no reset occurs from a-1 through the strobe edge.
  task automatic build_model();
    bit [3:0] mreg = 0;
    bit       mbs  = 0;
    bit [7:0] mwd  = 0;
    bit [7:0] mbd  = 0;
    for (int e = 0; e < len; e++) begin
      bit fire = 1'b0;
      bit wr = 1'b0;
      bit rd = 1'b0;
      int a = e - OFS;
      if (a >= 1 && e >= SYNC) begin
        fire = !scs(a-1);
        fire = !fire;
        for (int j = a; j <= e; j++) if (scs(j)) fire = 1'b0;
        for (int j = a - 1; j <= e; j++) if (p_rst[j]) fire = 1'b0;
      end
      if (p_rst[e]) begin
        mreg = 0; mbs = 0; mwd = 0; mbd = 0;
      end else begin
        if (e >= 2 && e_rd[e-2] && !p_rst[e-1]) begin
          mbd = mbs ? p_rdd[e][7:0] : p_rdd[e][15:8];
        end
        if (fire) begin
          wr   = !p_rd[e-SYNC];
          rd   = p_rd[e-SYNC];
          mreg = p_reg[e-SYNC];
          mbs  = p_bs[e-SYNC];
          mwd  = p_dat[e-SYNC];
        end
      end
      e_wr[e] = wr; e_rd[e] = rd; e_reg[e] = mreg; e_bs[e] = mbs; e_wd[e] = mwd; e_bd[e] = mbd;
    end
  endtask

  task automatic drive(input int i);
    reset_i       = p_rst[i];
    bus_cs_n_i    = p_cs[i];
    bus_rd_nwr_i  = p_rd[i];
    bus_bytesel_i = p_bs[i];
    bus_reg_num_i = p_reg[i];
    bus_data_i    = p_dat[i];
    reg_rd_data_i = p_rdd[i];
  endtask

  task automatic compare(input int e);
    check("wr_strobe", e, 16'(wr_strobe_o), 16'(e_wr[e]));
    check("rd_strobe", e, 16'(rd_strobe_o), 16'(e_rd[e]));
    check("reg_num",   e, 16'(reg_num_o),   16'(e_reg[e]));
    check("bytesel",   e, 16'(bytesel_o),   16'(e_bs[e]));
    check("wr_data",   e, 16'(wr_data_o),   16'(e_wd[e]));
    check("bus_data",  e, 16'(bus_data_o),  16'(e_bd[e]));
  endtask

  initial begin
    // Reset with select idle.
    seg(8, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 1);
    seg(4, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 0);
    // Write reg 3, odd byte, A5.
    seg(10, 0, 0, 1, 4'h3, 8'hA5, 16'h0000, 0);
    seg(6,  1, 0, 1, 4'h3, 8'hA5, 16'h0000, 0);
    // Reads of reg 7 returning BEEF, even then odd byte.
    seg(10, 0, 1, 0, 4'h7, 8'h00, 16'hBEEF, 0);
    seg(6,  1, 1, 0, 4'h7, 8'h00, 16'hBEEF, 0);
    seg(10, 0, 1, 1, 4'h7, 8'h00, 16'hBEEF, 0);
    seg(6,  1, 1, 1, 4'h7, 8'h00, 16'hBEEF, 0);
    // One-cycle glitch, then a 5-cycle select.
    seg(1,  0, 0, 0, 4'h9, 8'h66, 16'h1234, 0);
    seg(6,  1, 0, 0, 4'h9, 8'h66, 16'h1234, 0);
    seg(5,  0, 0, 0, 4'hA, 8'h77, 16'h1234, 0);
    seg(6,  1, 0, 0, 4'hA, 8'h77, 16'h1234, 0);
    // Long hold with data changing mid-cycle.
    seg(25, 0, 0, 1, 4'h5, 8'hA5, 16'h1234, 0);
    seg(25, 0, 0, 1, 4'h5, 8'h5A, 16'h1234, 0);
    seg(6,  1, 0, 1, 4'h5, 8'h5A, 16'h1234, 0);
    // Reset while armed, select held afterwards, then a fresh cycle.
    seg(3,  0, 0, 0, 4'hC, 8'h3C, 16'h1234, 0);
    seg(1,  0, 0, 0, 4'hC, 8'h3C, 16'h1234, 1);
    seg(20, 0, 0, 0, 4'hC, 8'h3C, 16'h1234, 0);
    seg(6,  1, 0, 0, 4'hC, 8'h3C, 16'h1234, 0);
    seg(10, 0, 0, 0, 4'hD, 8'h4D, 16'h1234, 0);
    seg(6,  1, 0, 0, 4'hD, 8'h4D, 16'h1234, 0);
    // Back-to-back writes with a 2-cycle gap, then with no gap.
    seg(10, 0, 0, 0, 4'h1, 8'h11, 16'h0000, 0);
    seg(2,  1, 0, 0, 4'h1, 8'h11, 16'h0000, 0);
    seg(10, 0, 0, 0, 4'h2, 8'h22, 16'h0000, 0);
    seg(6,  1, 0, 0, 4'h2, 8'h22, 16'h0000, 0);
    seg(10, 0, 0, 0, 4'h1, 8'h11, 16'h0000, 0);
    seg(10, 0, 0, 0, 4'h2, 8'h22, 16'h0000, 0);
    seg(6,  1, 0, 0, 4'h2, 8'h22, 16'h0000, 0);
    // Random bus traffic with occasional resets.
    for (int s = 0; s < 150; s++) begin
      bit        rd  = 1'($urandom);
      bit        bs  = 1'($urandom);
      bit [3:0]  rg  = 4'($urandom);
      bit [7:0]  d   = 8'($urandom);
      bit [15:0] rdd = 16'($urandom);
      seg($urandom_range(1, 10), 0, rd, bs, rg, d, rdd, 0);
      if ($urandom_range(0, 19) == 0) seg(1, 0, rd, bs, rg, d, rdd, 1);
      seg($urandom_range(0, 4), 1, rd, bs, rg, d, rdd, 0);
    end
    seg(8, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 0);

    build_model();
    drive(0);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i > 0) compare(i - 1);
      drive(i);
    end
    @(negedge clk);
    compare(len - 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
